vga_sync_monitor: RTL and testbench



---
 rtl/vga_params.sv | 18 +
 rtl/sync_edge_detect.sv | 31 +++
 rtl/vga_sync_monitor.sv | 185 ++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_params.sv
// rtl/vga_params.sv - 640x480 timing constants and sync-monitor state encoding
package vga_params;

  localparam int H_DISPLAY    = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_TOTAL      = 800;
  localparam int V_DISPLAY    = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_TOTAL      = 525;

  localparam logic SYNC_ACTIVE = 1'b1;
  localparam int   LOCK_FRAMES = 2;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - p_tick-qualified sync sampler with assertion-edge output
module sync_edge_detect #(
  parameter logic ACTIVE = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic p_tick_i,
  input  logic sync_i,
  output logic edge_o
);

  logic sample_q;
  logic sample_d;

  // Capture a new sample only on pixel ticks; otherwise hold.
  always_comb begin
    sample_d = p_tick_i ? sync_i : sample_q;
  end

  // History flop starts at the idle level so a sync already asserted at reset
  // release still counts as an edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) sample_q <= ~ACTIVE;
    else         sample_q <= sample_d;
  end

  // Edge is seen in the same clock that the new sample is registered, so the
  // position update in the parent lands on that clock too.
  assign edge_o = p_tick_i && (sync_i == ACTIVE) && (sample_q != ACTIVE);

endmodule

// File: rtl/vga_sync_monitor.sv
// rtl/vga_sync_monitor.sv - locks onto hsync/vsync, recovers position, flags timing errors
module vga_sync_monitor #(
  parameter int   H_DISPLAY    = vga_params::H_DISPLAY,
  parameter int   H_SYNC_START = vga_params::H_SYNC_START,
  parameter int   H_TOTAL      = vga_params::H_TOTAL,
  parameter int   V_DISPLAY    = vga_params::V_DISPLAY,
  parameter int   V_SYNC_START = vga_params::V_SYNC_START,
  parameter int   V_TOTAL      = vga_params::V_TOTAL,
  parameter logic SYNC_ACTIVE  = vga_params::SYNC_ACTIVE,
  parameter int   LOCK_FRAMES  = vga_params::LOCK_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       locked,
  output logic       frame_tick,
  output logic       sync_err,
  output logic [7:0] err_count
);
  import vga_params::*;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
  localparam logic [9:0] V_SS   = 10'(V_SYNC_START);
  localparam logic [9:0] H_DW   = 10'(H_DISPLAY);
  localparam logic [9:0] V_DW   = 10'(V_DISPLAY);
  localparam logic [3:0] LF     = 4'(LOCK_FRAMES);

  logic       hs_edge, vs_edge;
  logic [1:0] state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [9:0] nx, ny;
  logic [3:0] good_q, good_d;
  logic       wrap_evt_q, wrap_evt_d;
  logic       err_evt_q, err_evt_d;
  logic       violation, frame_wrap;

  logic [9:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic       video_on_q, video_on_d, locked_q, locked_d;
  logic       frame_tick_q, frame_tick_d, sync_err_q, sync_err_d;
  logic [7:0] err_count_q, err_count_d;

  sync_edge_detect #(.ACTIVE(SYNC_ACTIVE)) u_hs_edge (
    .clk_i   (clk),
    .reset_i (reset),
    .p_tick_i(p_tick),
    .sync_i  (hsync),
    .edge_o  (hs_edge)
  );

  sync_edge_detect #(.ACTIVE(SYNC_ACTIVE)) u_vs_edge (
    .clk_i   (clk),
    .reset_i (reset),
    .p_tick_i(p_tick),
    .sync_i  (vsync),
    .edge_o  (vs_edge)
  );

  // Predicted next position and the sync edges it implies.
  always_comb begin
    nx = '0;
    ny = y_q;
    if (x_q == H_LAST) begin
      ny = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end else begin
      nx = x_q + 10'd1;
    end
    frame_wrap = (nx == '0) && (ny == '0);
    violation  = p_tick && (state_q != ST_SEARCH) &&
                 ((hs_edge ^ (nx == H_SS)) || (vs_edge ^ ((nx == '0) && (ny == V_SS))));
  end

  // Acquisition FSM: search for vsync, verify clean frames, then track.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    good_d     = good_q;
    wrap_evt_d = 1'b0;
    err_evt_d  = 1'b0;
    if (p_tick) begin
      case (state_q)
        ST_SEARCH: begin
          if (vs_edge) begin
            x_d     = '0;
            y_d     = V_SS;
            good_d  = '0;
            state_d = ST_CHECK;
          end
        end
        ST_CHECK, ST_LOCKED: begin
          if (violation) begin
            state_d   = ST_SEARCH;
            x_d       = '0;
            y_d       = '0;
            err_evt_d = 1'b1;
          end else begin
            x_d = nx;
            y_d = ny;
            if (frame_wrap) begin
              if (state_q == ST_CHECK) begin
                good_d = good_q + 4'd1;
                if ((good_q + 4'd1) == LF) state_d = ST_LOCKED;
              end else begin
                wrap_evt_d = 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = ST_SEARCH;
          x_d     = '0;
          y_d     = '0;
        end
      endcase
    end
  end

  // Core state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SEARCH;
      x_q        <= '0;
      y_q        <= '0;
      good_q     <= '0;
      wrap_evt_q <= 1'b0;
      err_evt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      good_q     <= good_d;
      wrap_evt_q <= wrap_evt_d;
      err_evt_q  <= err_evt_d;
    end
  end

  // Output values derived from the already-updated core state.
  always_comb begin
    locked_d     = (state_q == ST_LOCKED);
    pixel_x_d    = locked_d ? x_q : '0;
    pixel_y_d    = locked_d ? y_q : '0;
    video_on_d   = locked_d && (x_q < H_DW) && (y_q < V_DW);
    frame_tick_d = wrap_evt_q;
    sync_err_d   = err_evt_q;
    err_count_d  = err_count_q;
    if (err_evt_q && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  // Output registers, one clock behind the core state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_x_q    <= '0;
      pixel_y_q    <= '0;
      video_on_q   <= 1'b0;
      locked_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      sync_err_q   <= 1'b0;
      err_count_q  <= '0;
    end else begin
      pixel_x_q    <= pixel_x_d;
      pixel_y_q    <= pixel_y_d;
      video_on_q   <= video_on_d;
      locked_q     <= locked_d;
      frame_tick_q <= frame_tick_d;
      sync_err_q   <= sync_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign pixel_x    = pixel_x_q;
  assign pixel_y    = pixel_y_q;
  assign video_on   = video_on_q;
  assign locked     = locked_q;
  assign frame_tick = frame_tick_q;
  assign sync_err   = sync_err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb/tb_vga_sync_monitor.sv - directed self-checking bench for vga_sync_monitor
module tb_vga_sync_monitor;

  localparam int HD  = 8;
  localparam int HSS = 10;
  localparam int HT  = 16;
  localparam int VD  = 6;
  localparam int VSS = 8;
  localparam int VT  = 12;

  logic clk = 1'b0;
  logic reset, p_tick, hsync, vsync;
  logic hsync_n, vsync_n;

  logic [9:0] pixel_x, pixel_y, pixel_x_n, pixel_y_n;
  logic       video_on, locked, frame_tick, sync_err;
  logic       video_on_n, locked_n, frame_tick_n, sync_err_n;
  logic [7:0] err_count, err_count_n;

  int total = 0;
  int bad   = 0;
  int ft_cnt = 0, ft_cnt_n = 0, se_cnt = 0, se_cnt_n = 0;
  int gx = 0, gy = 0, sx = 0, sy = 0;
  int gap = 1;
  bit vs_mask = 1'b0;

  assign hsync_n = ~hsync;
  assign vsync_n = ~vsync;

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_DISPLAY(HD), .H_SYNC_START(HSS), .H_TOTAL(HT),
    .V_DISPLAY(VD), .V_SYNC_START(VSS), .V_TOTAL(VT),
    .SYNC_ACTIVE(1'b1), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on), .locked(locked),
    .frame_tick(frame_tick), .sync_err(sync_err), .err_count(err_count)
  );

  vga_sync_monitor #(
    .H_DISPLAY(HD), .H_SYNC_START(HSS), .H_TOTAL(HT),
    .V_DISPLAY(VD), .V_SYNC_START(VSS), .V_TOTAL(VT),
    .SYNC_ACTIVE(1'b0), .LOCK_FRAMES(2)
  ) dut_n (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync_n), .vsync(vsync_n),
    .pixel_x(pixel_x_n), .pixel_y(pixel_y_n), .video_on(video_on_n), .locked(locked_n),
    .frame_tick(frame_tick_n), .sync_err(sync_err_n), .err_count(err_count_n)
  );

  // Pulse counters sampled once per clock; a stretched pulse counts twice.
  always @(posedge clk) begin
    #1;
    if (frame_tick   === 1'b1) ft_cnt   = ft_cnt + 1;
    if (frame_tick_n === 1'b1) ft_cnt_n = ft_cnt_n + 1;
    if (sync_err     === 1'b1) se_cnt   = se_cnt + 1;
    if (sync_err_n   === 1'b1) se_cnt_n = se_cnt_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pair(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    chk(tag, a, exp);
    chk({tag, "_n"}, b, exp);
  endtask

  task automatic chk_all(input string tag, input int px, input int py, input int von,
                         input int lk, input int ft, input int se, input int ec);
    chk_pair({tag, ".px"}, 32'(pixel_x), 32'(pixel_x_n), px);
    chk_pair({tag, ".py"}, 32'(pixel_y), 32'(pixel_y_n), py);
    chk_pair({tag, ".von"}, 32'(video_on), 32'(video_on_n), von);
    chk_pair({tag, ".lock"}, 32'(locked), 32'(locked_n), lk);
    chk_pair({tag, ".ft"}, 32'(frame_tick), 32'(frame_tick_n), ft);
    chk_pair({tag, ".se"}, 32'(sync_err), 32'(sync_err_n), se);
    chk_pair({tag, ".ec"}, 32'(err_count), 32'(err_count_n), ec);
  endtask

  task automatic chk_counts(input string tag, input int ft, input int se);
    chk_pair({tag, ".ftcnt"}, ft_cnt, ft_cnt_n, ft);
    chk_pair({tag, ".secnt"}, se_cnt, se_cnt_n, se);
  endtask

  // One p_tick clock followed by gap idle clocks; returns 2 time units after an edge.
  task automatic pulse();
    p_tick = 1'b1;
    @(posedge clk); #2;
    p_tick = 1'b0;
    repeat (gap) @(posedge clk);
    #2;
  endtask

  task automatic gen_step(input bit hold, input bit track);
    hsync = (gx >= HSS) && (gx < HSS + 2);
    vsync = !vs_mask && (gy >= VSS) && (gy < VSS + 2);
    pulse();
    sx = gx;
    sy = gy;
    if (!hold) begin
      if (gx == HT - 1) begin
        gx = 0;
        gy = (gy == VT - 1) ? 0 : gy + 1;
      end else begin
        gx = gx + 1;
      end
    end
    if (track) begin
      chk_pair("trk.px", 32'(pixel_x), 32'(pixel_x_n), sx);
      chk_pair("trk.py", 32'(pixel_y), 32'(pixel_y_n), sy);
      chk_pair("trk.von", 32'(video_on), 32'(video_on_n), 32'((sx < HD) && (sy < VD)));
      chk_pair("trk.lock", 32'(locked), 32'(locked_n), 1);
    end
  endtask

  task automatic raw_step(input logic h, input logic v);
    hsync = h;
    vsync = v;
    pulse();
  endtask

  task automatic run_to_origin(input int n, input bit track);
    int seen = 0;
    for (int g = 0; g < 2000 && seen < n; g++) begin
      gen_step(1'b0, track);
      if (sx == 0 && sy == 0) seen++;
    end
    chk("origin_reached", seen, n);
  endtask

  task automatic run_to(input int tx, input int ty, input bit track);
    for (int g = 0; g < 2000 && !(gx == tx && gy == ty); g++) gen_step(1'b0, track);
    chk("reach_x", gx, tx);
    chk("reach_y", gy, ty);
  endtask

  initial begin
    reset = 1'b1; p_tick = 1'b0; hsync = 1'b0; vsync = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Acquire: vsync edge at (0,8), origin -> 1 good frame, next origin -> locked.
    repeat (384) gen_step(1'b0, 1'b0);
    chk_pair("prelock", 32'(locked), 32'(locked_n), 0);
    chk_counts("prelock", 0, 0);
    gen_step(1'b0, 1'b1);
    chk_all("lock1", 0, 0, 1, 1, 0, 0, 0);

    // Tracking over two frames at different p_tick spacings; one frame_tick each.
    gap = 3;
    run_to_origin(1, 1'b1);
    chk_counts("frame1", 1, 0);
    gap = 2;
    run_to_origin(1, 1'b1);
    chk_counts("frame2", 2, 0);
    gap = 1;

    // Stretch line 2 to 17 ticks; the missing hsync edge at x=10 is caught at (9,3).
    run_to(15, 2, 1'b1);
    gen_step(1'b1, 1'b1);
    repeat (10) gen_step(1'b0, 1'b0);
    chk_pair("prestretch.ec", 32'(err_count), 32'(err_count_n), 0);
    gen_step(1'b0, 1'b0);
    chk_all("stretch", 0, 0, 0, 0, 0, 1, 1);
    run_to_origin(1, 1'b0);
    chk_pair("relock1.pre", 32'(locked), 32'(locked_n), 0);
    run_to_origin(1, 1'b0);
    chk_all("relock1", 0, 0, 1, 1, 0, 0, 1);
    chk_counts("relock1", 2, 1);

    // Suppress one vsync pulse: violation at (0,8); re-arm on the next frame's vsync.
    vs_mask = 1'b1;
    run_to(0, 8, 1'b1);
    gen_step(1'b0, 1'b0);
    chk_all("vsup", 0, 0, 0, 0, 0, 1, 2);
    run_to(0, 10, 1'b0);
    vs_mask = 1'b0;
    run_to_origin(2, 1'b0);
    chk_pair("relock2.pre", 32'(locked), 32'(locked_n), 0);
    run_to_origin(1, 1'b0);
    chk_all("relock2", 0, 0, 1, 1, 0, 0, 2);

    // Asynchronous reset mid-frame while locked clears everything at once.
    run_to(4, 3, 1'b1);
    reset = 1'b1;
    #1;
    chk_all("midrst", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    run_to_origin(1, 1'b0);
    chk_pair("relock3.pre", 32'(locked), 32'(locked_n), 0);
    run_to_origin(1, 1'b0);
    chk_all("relock3", 0, 0, 1, 1, 0, 0, 0);
    run_to_origin(1, 1'b1);
    chk_counts("frame3", 3, 2);

    // A vsync edge coinciding with a violation must not re-arm the checker.
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    raw_step(1'b0, 1'b1);
    raw_step(1'b0, 1'b0);
    chk_pair("rearm.ec0", 32'(err_count), 32'(err_count_n), 0);
    raw_step(1'b0, 1'b1);
    raw_step(1'b1, 1'b1);
    raw_step(1'b0, 1'b0);
    chk_pair("rearm.ec1", 32'(err_count), 32'(err_count_n), 1);
    chk_counts("rearm", 3, 3);

    // Saturation: 300 more violations, counter stops at 255.
    for (int i = 0; i < 254; i++) begin
      raw_step(1'b0, 1'b1);
      raw_step(1'b1, 1'b1);
      raw_step(1'b0, 1'b0);
    end
    chk_pair("sat255.ec", 32'(err_count), 32'(err_count_n), 255);
    chk_counts("sat255", 3, 257);
    for (int i = 0; i < 46; i++) begin
      raw_step(1'b0, 1'b1);
      raw_step(1'b1, 1'b1);
      raw_step(1'b0, 1'b0);
    end
    chk_pair("sat_hold.ec", 32'(err_count), 32'(err_count_n), 255);
    chk_pair("sat_hold.lock", 32'(locked), 32'(locked_n), 0);
    chk_counts("sat_hold", 3, 303);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
